// File: rtl/csr_regfile.sv
`default_nettype none
// ============================================================================
// Module   : csr_regfile
// Purpose  : LoongArch control/status register file. Consumes the writeback
//            stage's CSR write, exception-commit and ertn-commit strobes.
//            Serves combinational CSR reads to decode, supplies the exception
//            entry and ertn return PCs to fetch, runs the constant timer and
//            produces the pending-interrupt flag.
// Ports    : clk, resetn       - clock, asynchronous active-low reset
//            csr_we/num/wmask/wvalue - masked CSR write from WB
//            wb_ex/ecode/esubcode/pc - exception commit from WB
//            ertn_flush        - ertn commit from WB
//            rd_csr_num/csr_rvalue   - combinational read port for ID
//            ex_entry/ertn_entry     - EENTRY / ERA to IF
//            has_int           - enabled interrupt pending
//            hw_int_in/ipi_int_in    - level interrupt inputs
// Revision : 1.0 - initial release
// ============================================================================
module csr_regfile #(
   parameter int          TIMER_W   = 32,
   parameter logic [31:0] TID_RESET = 32'h0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        csr_we,
   input  logic [13:0] csr_num,
   input  logic [31:0] csr_wmask,
   input  logic [31:0] csr_wvalue,
   input  logic        wb_ex,
   input  logic [5:0]  wb_ecode,
   input  logic [8:0]  wb_esubcode,
   input  logic [31:0] wb_pc,
   input  logic        ertn_flush,
   input  logic [13:0] rd_csr_num,
   output logic [31:0] csr_rvalue,
   output logic [31:0] ex_entry,
   output logic [31:0] ertn_entry,
   output logic        has_int,
   input  logic [7:0]  hw_int_in,
   input  logic        ipi_int_in
);

   // CSR addresses
   localparam logic [13:0] c_CRMD   = 14'h00;
   localparam logic [13:0] c_PRMD   = 14'h01;
   localparam logic [13:0] c_ECFG   = 14'h04;
   localparam logic [13:0] c_ESTAT  = 14'h05;
   localparam logic [13:0] c_ERA    = 14'h06;
   localparam logic [13:0] c_BADV   = 14'h07;
   localparam logic [13:0] c_EENTRY = 14'h0C;
   localparam logic [13:0] c_SAVE0  = 14'h30;
   localparam logic [13:0] c_SAVE1  = 14'h31;
   localparam logic [13:0] c_SAVE2  = 14'h32;
   localparam logic [13:0] c_SAVE3  = 14'h33;
   localparam logic [13:0] c_TID    = 14'h40;
   localparam logic [13:0] c_TCFG   = 14'h41;
   localparam logic [13:0] c_TVAL   = 14'h42;
   localparam logic [13:0] c_TICLR  = 14'h44;

   // ECFG.LIE bit 10 does not exist
   localparam logic [12:0] c_ECFG_MASK = 13'h1BFF;
   localparam logic [TIMER_W-1:0] c_TVAL_ONE = {{(TIMER_W-1){1'b0}}, 1'b1};

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [4:0]         crmd_q,      crmd_d;       // PG,DA,IE,PLV[1:0]
   logic [2:0]         prmd_q,      prmd_d;       // PIE,PPLV[1:0]
   logic [12:0]        ecfg_q,      ecfg_d;
   logic [1:0]         sw_is_q,     sw_is_d;
   logic [7:0]         hw_is_q,     hw_is_d;
   logic               ipi_is_q,    ipi_is_d;
   logic               timer_is_q,  timer_is_d;
   logic [5:0]         ecode_q,     ecode_d;
   logic [8:0]         esub_q,      esub_d;
   logic [31:0]        era_q,       era_d;
   logic [31:0]        badv_q,      badv_d;
   logic [25:0]        eentry_q,    eentry_d;
   logic [31:0]        save_q [4];
   logic [31:0]        save_d [4];
   logic [31:0]        tid_q,       tid_d;
   logic [TIMER_W-1:0] tcfg_q,      tcfg_d;
   logic [TIMER_W-1:0] tval_q,      tval_d;
   logic               timer_en_q,  timer_en_d;

   logic [31:0] w_wdata;
   logic        w_tcfg_wr;
   logic        w_ticlr;
   logic        w_timer_set;
   logic [31:0] w_tcfg_ext;
   logic [31:0] w_tval_ext;
   logic [12:0] w_is;
   logic [31:0] w_rdata;

   function automatic logic [31:0] f_mw(input logic [31:0] old_v,
                                        input logic [31:0] wmask,
                                        input logic [31:0] wvalue);
      return (old_v & ~wmask) | (wvalue & wmask);
   endfunction

   // Zero-extended views of the timer registers (TIMER_W may be 32)
   always_comb begin
      w_tcfg_ext                = '0;
      w_tcfg_ext[TIMER_W-1:0]   = tcfg_q;
      w_tval_ext                = '0;
      w_tval_ext[TIMER_W-1:0]   = tval_q;
   end

   assign w_is = {ipi_is_q, timer_is_q, 1'b0, hw_is_q, sw_is_q};

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      crmd_d      = crmd_q;
      prmd_d      = prmd_q;
      ecfg_d      = ecfg_q;
      sw_is_d     = sw_is_q;
      hw_is_d     = hw_int_in;
      ipi_is_d    = ipi_int_in;
      timer_is_d  = timer_is_q;
      ecode_d     = ecode_q;
      esub_d      = esub_q;
      era_d       = era_q;
      badv_d      = badv_q;
      eentry_d    = eentry_q;
      save_d      = save_q;
      tid_d       = tid_q;
      tcfg_d      = tcfg_q;
      tval_d      = tval_q;
      timer_en_d  = timer_en_q;
      w_wdata     = '0;
      w_tcfg_wr   = 1'b0;
      w_ticlr     = 1'b0;
      w_timer_set = 1'b0;

      // Exception beats ertn beats CSR write; losers are dropped
      if (wb_ex) begin
         prmd_d      = crmd_q[2:0];
         crmd_d[2:0] = 3'b000;
         era_d       = wb_pc;
         ecode_d     = wb_ecode;
         esub_d      = wb_esubcode;
      end else if (ertn_flush) begin
         crmd_d[2:0] = prmd_q;
      end else if (csr_we) begin
         case (csr_num)
            c_CRMD: begin
               w_wdata = f_mw({27'b0, crmd_q}, csr_wmask, csr_wvalue);
               crmd_d  = w_wdata[4:0];
            end
            c_PRMD: begin
               w_wdata = f_mw({29'b0, prmd_q}, csr_wmask, csr_wvalue);
               prmd_d  = w_wdata[2:0];
            end
            c_ECFG: begin
               w_wdata = f_mw({19'b0, ecfg_q}, csr_wmask, csr_wvalue);
               ecfg_d  = w_wdata[12:0] & c_ECFG_MASK;
            end
            c_ESTAT: begin
               // only IS[1:0] is software-writable
               w_wdata = f_mw({30'b0, sw_is_q}, csr_wmask, csr_wvalue);
               sw_is_d = w_wdata[1:0];
            end
            c_ERA: begin
               w_wdata = f_mw(era_q, csr_wmask, csr_wvalue);
               era_d   = w_wdata;
            end
            c_BADV: begin
               w_wdata = f_mw(badv_q, csr_wmask, csr_wvalue);
               badv_d  = w_wdata;
            end
            c_EENTRY: begin
               w_wdata  = f_mw({eentry_q, 6'b0}, csr_wmask, csr_wvalue);
               eentry_d = w_wdata[31:6];
            end
            c_SAVE0, c_SAVE1, c_SAVE2, c_SAVE3: begin
               w_wdata                 = f_mw(save_q[csr_num[1:0]], csr_wmask, csr_wvalue);
               save_d[csr_num[1:0]]    = w_wdata;
            end
            c_TID: begin
               w_wdata = f_mw(tid_q, csr_wmask, csr_wvalue);
               tid_d   = w_wdata;
            end
            c_TCFG: begin
               w_wdata   = f_mw(w_tcfg_ext, csr_wmask, csr_wvalue);
               tcfg_d    = w_wdata[TIMER_W-1:0];
               w_tcfg_wr = 1'b1;
            end
            c_TICLR: begin
               w_ticlr = csr_wvalue[0] & csr_wmask[0];
            end
            default: ;
         endcase
      end

      // Timer: a TCFG write restarts the count and overrides this cycle's tick
      if (w_tcfg_wr) begin
         timer_en_d = tcfg_d[0];
         tval_d     = {tcfg_d[TIMER_W-1:2], 2'b00};
      end else if (timer_en_q) begin
         if (tval_q != '0) begin
            tval_d = tval_q - c_TVAL_ONE;
         end else begin
            w_timer_set = 1'b1;
            if (tcfg_q[1]) begin
               tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
            end else begin
               timer_en_d = 1'b0;
            end
         end
      end

      // An expiry in the same cycle as TICLR keeps the interrupt pending
      if (w_timer_set) begin
         timer_is_d = 1'b1;
      end else if (w_ticlr) begin
         timer_is_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         crmd_q     <= 5'h08;
         prmd_q     <= '0;
         ecfg_q     <= '0;
         sw_is_q    <= '0;
         hw_is_q    <= '0;
         ipi_is_q   <= 1'b0;
         timer_is_q <= 1'b0;
         ecode_q    <= '0;
         esub_q     <= '0;
         era_q      <= '0;
         badv_q     <= '0;
         eentry_q   <= '0;
         for (int i = 0; i < 4; i++) begin
            save_q[i] <= '0;
         end
         tid_q      <= TID_RESET;
         tcfg_q     <= '0;
         tval_q     <= '0;
         timer_en_q <= 1'b0;
      end else begin
         crmd_q     <= crmd_d;
         prmd_q     <= prmd_d;
         ecfg_q     <= ecfg_d;
         sw_is_q    <= sw_is_d;
         hw_is_q    <= hw_is_d;
         ipi_is_q   <= ipi_is_d;
         timer_is_q <= timer_is_d;
         ecode_q    <= ecode_d;
         esub_q     <= esub_d;
         era_q      <= era_d;
         badv_q     <= badv_d;
         eentry_q   <= eentry_d;
         save_q     <= save_d;
         tid_q      <= tid_d;
         tcfg_q     <= tcfg_d;
         tval_q     <= tval_d;
         timer_en_q <= timer_en_d;
      end
   end

   // ------------------------------------------------------------------------
   // Read port and outputs (no write bypass; ID resolves hazards)
   // ------------------------------------------------------------------------
   always_comb begin
      w_rdata = '0;
      case (rd_csr_num)
         c_CRMD:   w_rdata = {27'b0, crmd_q};
         c_PRMD:   w_rdata = {29'b0, prmd_q};
         c_ECFG:   w_rdata = {19'b0, ecfg_q};
         c_ESTAT:  w_rdata = {1'b0, esub_q, ecode_q, 3'b0, w_is};
         c_ERA:    w_rdata = era_q;
         c_BADV:   w_rdata = badv_q;
         c_EENTRY: w_rdata = {eentry_q, 6'b0};
         c_SAVE0:  w_rdata = save_q[0];
         c_SAVE1:  w_rdata = save_q[1];
         c_SAVE2:  w_rdata = save_q[2];
         c_SAVE3:  w_rdata = save_q[3];
         c_TID:    w_rdata = tid_q;
         c_TCFG:   w_rdata = w_tcfg_ext;
         c_TVAL:   w_rdata = w_tval_ext;
         default:  w_rdata = '0;
      endcase
   end

   assign csr_rvalue = w_rdata;
   assign ex_entry   = {eentry_q, 6'b0};
   assign ertn_entry = era_q;
   assign has_int    = crmd_q[2] & (|(w_is & ecfg_q));

endmodule
`default_nettype wire

// File: tb/tb_csr_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_regfile
// Purpose  : Directed self-checking bench for csr_regfile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_regfile;

   logic        clk = 1'b0;
   logic        resetn;
   logic        csr_we;
   logic [13:0] csr_num;
   logic [31:0] csr_wmask;
   logic [31:0] csr_wvalue;
   logic        wb_ex;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_pc;
   logic        ertn_flush;
   logic [13:0] rd_csr_num;
   logic [31:0] csr_rvalue;
   logic [31:0] ex_entry;
   logic [31:0] ertn_entry;
   logic        has_int;
   logic [7:0]  hw_int_in;
   logic        ipi_int_in;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] rv;

   csr_regfile #(.TIMER_W(32), .TID_RESET(32'h0)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .csr_we      (csr_we),
      .csr_num     (csr_num),
      .csr_wmask   (csr_wmask),
      .csr_wvalue  (csr_wvalue),
      .wb_ex       (wb_ex),
      .wb_ecode    (wb_ecode),
      .wb_esubcode (wb_esubcode),
      .wb_pc       (wb_pc),
      .ertn_flush  (ertn_flush),
      .rd_csr_num  (rd_csr_num),
      .csr_rvalue  (csr_rvalue),
      .ex_entry    (ex_entry),
      .ertn_entry  (ertn_entry),
      .has_int     (has_int),
      .hw_int_in   (hw_int_in),
      .ipi_int_in  (ipi_int_in)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_write(input logic [13:0] num, input logic [31:0] mask,
                            input logic [31:0] val);
      csr_we = 1'b1; csr_num = num; csr_wmask = mask; csr_wvalue = val;
      tick();
      csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
   endtask

   task automatic read_csr(input logic [13:0] num, output logic [31:0] val);
      rd_csr_num = num;
      #1;
      val = csr_rvalue;
   endtask

   task automatic test_reset();
      read_csr(14'h00, rv);
      n_checks++; if (rv !== 32'h8) $display("FAIL crmd_reset: got %h expected %h", rv, 32'h8); else n_pass++;
      read_csr(14'h40, rv);
      n_checks++; if (rv !== 32'h0) $display("FAIL tid_reset: got %h expected %h", rv, 32'h0); else n_pass++;
      n_checks++; if (ex_entry !== 32'h0) $display("FAIL ex_entry_reset: got %h expected %h", ex_entry, 32'h0); else n_pass++;
      n_checks++; if (has_int !== 1'b0) $display("FAIL has_int_reset: got %h expected %h", has_int, 1'b0); else n_pass++;
      @(negedge clk);
      resetn = 1'b1;
      tick();
      read_csr(14'h42, rv);
      n_checks++; if (rv !== 32'h0) $display("FAIL tval_reset: got %h expected %h", rv, 32'h0); else n_pass++;
   endtask

   task automatic test_fields();
      csr_write(14'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      read_csr(14'h00, rv);
      n_checks++; if (rv !== 32'h1F) $display("FAIL crmd_fields: got %h expected %h", rv, 32'h1F); else n_pass++;
      csr_write(14'h00, 32'hFFFF_FFFF, 32'h8);
      csr_write(14'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      read_csr(14'h04, rv);
      n_checks++; if (rv !== 32'h1BFF) $display("FAIL ecfg_fields: got %h expected %h", rv, 32'h1BFF); else n_pass++;
      csr_write(14'h04, 32'hFFFF_FFFF, 32'h0);
      csr_write(14'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      read_csr(14'h01, rv);
      n_checks++; if (rv !== 32'h7) $display("FAIL prmd_fields: got %h expected %h", rv, 32'h7); else n_pass++;
      csr_write(14'h01, 32'hFFFF_FFFF, 32'h0);
      csr_write(14'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      read_csr(14'h10, rv);
      n_checks++; if (rv !== 32'h0) $display("FAIL unknown_csr: got %h expected %h", rv, 32'h0); else n_pass++;
   endtask

   task automatic test_eentry();
      csr_write(14'h0C, 32'hFFFF_FFFF, 32'h1C00_8FFF);
      n_checks++; if (ex_entry !== 32'h1C00_8FC0) $display("FAIL ex_entry: got %h expected %h", ex_entry, 32'h1C00_8FC0); else n_pass++;
      read_csr(14'h0C, rv);
      n_checks++; if (rv !== 32'h1C00_8FC0) $display("FAIL eentry_read: got %h expected %h", rv, 32'h1C00_8FC0); else n_pass++;
   endtask

   task automatic test_exception();
      csr_write(14'h00, 32'h7, 32'h7);
      wb_ex = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 9'h001; wb_pc = 32'h1C00_0100;
      tick();
      wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0; wb_pc = '0;
      read_csr(14'h01, rv);
      n_checks++; if (rv !== 32'h7) $display("FAIL ex_prmd: got %h expected %h", rv, 32'h7); else n_pass++;
      read_csr(14'h00, rv);
      n_checks++; if (rv !== 32'h8) $display("FAIL ex_crmd: got %h expected %h", rv, 32'h8); else n_pass++;
      n_checks++; if (ertn_entry !== 32'h1C00_0100) $display("FAIL ex_era: got %h expected %h", ertn_entry, 32'h1C00_0100); else n_pass++;
      read_csr(14'h05, rv);
      n_checks++; if (rv !== 32'h004B_0000) $display("FAIL ex_estat: got %h expected %h", rv, 32'h004B_0000); else n_pass++;
      ertn_flush = 1'b1;
      tick();
      ertn_flush = 1'b0;
      read_csr(14'h00, rv);
      n_checks++; if (rv !== 32'hF) $display("FAIL ertn_crmd: got %h expected %h", rv, 32'hF); else n_pass++;
   endtask

   task automatic test_priority();
      csr_write(14'h30, 32'hFFFF_FFFF, 32'h0000_1111);
      csr_we = 1'b1; csr_num = 14'h30; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'h0000_DEAD;
      wb_ex = 1'b1; wb_pc = 32'h1C00_0200;
      tick();
      csr_we = 1'b0; wb_ex = 1'b0; wb_pc = '0;
      read_csr(14'h30, rv);
      n_checks++; if (rv !== 32'h0000_1111) $display("FAIL ex_beats_we: got %h expected %h", rv, 32'h0000_1111); else n_pass++;
      csr_we = 1'b1; csr_num = 14'h32; csr_wvalue = 32'h0000_BEEF;
      ertn_flush = 1'b1;
      tick();
      csr_we = 1'b0; ertn_flush = 1'b0;
      read_csr(14'h32, rv);
      n_checks++; if (rv !== 32'h0) $display("FAIL ertn_beats_we: got %h expected %h", rv, 32'h0); else n_pass++;
      csr_write(14'h31, 32'hFFFF_FFFF, 32'h1234_5678);
      csr_write(14'h31, 32'h0000_FFFF, 32'hAAAA_BBBB);
      read_csr(14'h31, rv);
      n_checks++; if (rv !== 32'h1234_BBBB) $display("FAIL masked_save1: got %h expected %h", rv, 32'h1234_BBBB); else n_pass++;
   endtask

   task automatic test_timer_periodic();
      csr_write(14'h04, 32'hFFFF_FFFF, 32'h0000_0800);
      csr_write(14'h00, 32'h4, 32'h4);
      csr_write(14'h41, 32'hFFFF_FFFF, 32'h0000_000B);
      for (int i = 0; i <= 8; i++) begin
         read_csr(14'h42, rv);
         n_checks++; if (rv !== 32'(8 - i)) $display("FAIL tval_count[%0d]: got %h expected %h", i, rv, 32'(8 - i)); else n_pass++;
         if (i < 8) tick();
      end
      n_checks++; if (has_int !== 1'b0) $display("FAIL has_int_before_expiry: got %h expected %h", has_int, 1'b0); else n_pass++;
      tick();
      read_csr(14'h05, rv);
      n_checks++; if (rv[11] !== 1'b1) $display("FAIL timer_is_set: got %h expected %h", rv[11], 1'b1); else n_pass++;
      n_checks++; if (has_int !== 1'b1) $display("FAIL timer_has_int: got %h expected %h", has_int, 1'b1); else n_pass++;
      read_csr(14'h42, rv);
      n_checks++; if (rv !== 32'h8) $display("FAIL tval_reload: got %h expected %h", rv, 32'h8); else n_pass++;
      csr_write(14'h44, 32'h1, 32'h1);
      read_csr(14'h05, rv);
      n_checks++; if (rv[11] !== 1'b0) $display("FAIL ticlr_clear: got %h expected %h", rv[11], 1'b0); else n_pass++;
      n_checks++; if (has_int !== 1'b0) $display("FAIL has_int_after_clr: got %h expected %h", has_int, 1'b0); else n_pass++;
      read_csr(14'h44, rv);
      n_checks++; if (rv !== 32'h0) $display("FAIL ticlr_read: got %h expected %h", rv, 32'h0); else n_pass++;
      csr_write(14'h41, 32'hFFFF_FFFF, 32'h0);
   endtask

   task automatic test_timer_oneshot();
      csr_write(14'h41, 32'hFFFF_FFFF, 32'h0000_0005);
      read_csr(14'h42, rv);
      n_checks++; if (rv !== 32'h4) $display("FAIL oneshot_load: got %h expected %h", rv, 32'h4); else n_pass++;
      repeat (4) tick();
      read_csr(14'h42, rv);
      n_checks++; if (rv !== 32'h0) $display("FAIL oneshot_zero: got %h expected %h", rv, 32'h0); else n_pass++;
      tick();
      read_csr(14'h05, rv);
      n_checks++; if (rv[11] !== 1'b1) $display("FAIL oneshot_is: got %h expected %h", rv[11], 1'b1); else n_pass++;
      csr_write(14'h44, 32'hFFFF_FFFF, 32'h1);
      repeat (6) tick();
      read_csr(14'h05, rv);
      n_checks++; if (rv[11] !== 1'b0) $display("FAIL oneshot_no_reset: got %h expected %h", rv[11], 1'b0); else n_pass++;
      read_csr(14'h42, rv);
      n_checks++; if (rv !== 32'h0) $display("FAIL oneshot_tval_hold: got %h expected %h", rv, 32'h0); else n_pass++;
      // hardware interrupt line 0 -> IS[2]
      csr_write(14'h04, 32'hFFFF_FFFF, 32'h0000_0004);
      hw_int_in = 8'h01;
      tick();
      tick();
      n_checks++; if (has_int !== 1'b1) $display("FAIL hw_has_int: got %h expected %h", has_int, 1'b1); else n_pass++;
      read_csr(14'h05, rv);
      n_checks++; if (rv[12:0] !== 13'h0004) $display("FAIL hw_is: got %h expected %h", rv[12:0], 13'h0004); else n_pass++;
      hw_int_in = 8'h00;
      tick();
      tick();
      n_checks++; if (has_int !== 1'b0) $display("FAIL hw_has_int_drop: got %h expected %h", has_int, 1'b0); else n_pass++;
   endtask

   task automatic test_async_reset();
      csr_write(14'h04, 32'hFFFF_FFFF, 32'h0000_0001);
      csr_write(14'h05, 32'hFFFF_FFFF, 32'h0000_0001);
      csr_write(14'h41, 32'hFFFF_FFFF, 32'h0000_000B);
      n_checks++; if (has_int !== 1'b1) $display("FAIL sw_has_int: got %h expected %h", has_int, 1'b1); else n_pass++;
      repeat (3) tick();
      #2;
      resetn = 1'b0;
      #1;
      n_checks++; if (has_int !== 1'b0) $display("FAIL async_has_int: got %h expected %h", has_int, 1'b0); else n_pass++;
      n_checks++; if (ex_entry !== 32'h0) $display("FAIL async_ex_entry: got %h expected %h", ex_entry, 32'h0); else n_pass++;
      n_checks++; if (ertn_entry !== 32'h0) $display("FAIL async_ertn_entry: got %h expected %h", ertn_entry, 32'h0); else n_pass++;
      read_csr(14'h00, rv);
      n_checks++; if (rv !== 32'h8) $display("FAIL async_crmd: got %h expected %h", rv, 32'h8); else n_pass++;
      read_csr(14'h42, rv);
      n_checks++; if (rv !== 32'h0) $display("FAIL async_tval: got %h expected %h", rv, 32'h0); else n_pass++;
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) tick();
      read_csr(14'h42, rv);
      n_checks++; if (rv !== 32'h0) $display("FAIL count_abandoned: got %h expected %h", rv, 32'h0); else n_pass++;
   endtask

   initial begin
      resetn = 1'b0;
      csr_we = 1'b0; csr_num = '0; csr_wmask = '0; csr_wvalue = '0;
      wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0; wb_pc = '0;
      ertn_flush = 1'b0; rd_csr_num = '0; hw_int_in = '0; ipi_int_in = 1'b0;
      #12;
      test_reset();
      test_fields();
      test_eentry();
      test_exception();
      test_priority();
      test_timer_periodic();
      test_timer_oneshot();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
Control/status register file for the LoongArch pipeline. It is the consumer of the writeback stage's CSR/exception interface.
- Applies masked CSR writes, exception entry and ertn return.
- Serves combinational CSR reads to ID.
- Supplies exception-entry and ertn-return PCs to IF.
- Runs the constant timer and produces the pending-interrupt flag.

Parameters:
TIMER_W, 32, width of TCFG.InitVal+2 and TVAL counter (max 32)
TID_RESET, 32'h0, reset value of TID

Ports:
clk  input  1  clock
resetn  input  1  reset, asynchronous, active-low
csr_we  input  1  write strobe from WB (already qualified by WB valid)
csr_num  input  14  write address
csr_wmask  input  32  bit write mask
csr_wvalue  input  32  write data
wb_ex  input  1  exception commit from WB
wb_ecode  input  6  exception code
wb_esubcode  input  9  exception subcode
wb_pc  input  32  PC of excepting instruction
ertn_flush  input  1  ertn commit from WB
rd_csr_num  input  14  read address from ID
csr_rvalue  output  32  read data, combinational
ex_entry  output  32  EENTRY value
ertn_entry  output  32  ERA value
has_int  output  1  interrupt pending and enabled
hw_int_in  input  8  external interrupts, level, sampled each cycle
ipi_int_in  input  1  inter-processor interrupt, level

Behaviour:
Implemented CSRs (num, writable fields); unlisted bits read 0 and are not writable:
- CRMD 0x00: PLV[1:0], IE[2], DA[3], PG[4]. Reset 32'h8.
- PRMD 0x01: PPLV[1:0], PIE[2]. Reset 0.
- ECFG 0x04: LIE[9:0], LIE[12:11]. Reset 0.
- ESTAT 0x05:
  - IS[1:0] software-writable.
  - IS[9:2] = hw_int_in registered each cycle.
  - IS[11] timer.
  - IS[12] = ipi_int_in registered.
  - Ecode[21:16], EsubCode[30:22] written only by exception.
  - Reset 0.
- ERA 0x06: all bits. Reset 0.
- BADV 0x07: all bits. Reset 0.
- EENTRY 0x0C: VA[31:6]. Reset 0.
- SAVE0-3 0x30-0x33: all bits. Reset 0.
- TID 0x40: all bits. Reset TID_RESET.
- TCFG 0x41: En[0], Periodic[1], InitVal[TIMER_W-1:2]. Reset 0.
- TVAL 0x42: read-only, TIMER_W bits zero-extended. Reset 0.
- TICLR 0x44: write-only CLR[0]; always reads 0.

Masked write:
- new = (old & ~wmask) | (wvalue & wmask), restricted to writable fields.
- Takes effect at the next posedge.
- Unknown csr_num: write ignored, read returns 0.

Read: csr_rvalue is a pure combinational function of rd_csr_num and current register state. There is no write-to-read bypass; ID handles hazards.

Priority per cycle: wb_ex > ertn_flush > csr_we. Lower-priority events in the same cycle are dropped.

wb_ex (one cycle):
- PRMD.PPLV<=CRMD.PLV; PRMD.PIE<=CRMD.IE.
- CRMD.PLV<=0; CRMD.IE<=0.
- ERA<=wb_pc.
- ESTAT.Ecode<=wb_ecode; ESTAT.EsubCode<=wb_esubcode.

ertn_flush: CRMD.PLV<=PRMD.PPLV; CRMD.IE<=PRMD.PIE.

Outputs:
- ex_entry = EENTRY. ertn_entry = ERA.
- Both reflect register state; updates are visible the cycle after the write.

has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]). Registered-state combinational; 0 at reset.

Timer, with internal timer_en:
- TCFG write: timer_en<=new En; TVAL<={new InitVal,2'b00}. This overrides any decrement that cycle.
- Else if timer_en & TVAL!=0: TVAL<=TVAL-1.
- Else if timer_en & TVAL==0:
  - ESTAT.IS[11]<=1.
  - If Periodic: TVAL<={InitVal,2'b00}.
  - Else: timer_en<=0; TVAL holds 0.
- TICLR write with (wvalue&wmask)[0]=1 clears IS[11].
- Timer set and TICLR clear in the same cycle: set wins.

Reset: async assertion clears all state to the reset values above and drives all outputs to reset-derived values (ex_entry=0, ertn_entry=0, has_int=0, csr_rvalue per reset state). Deassertion is synchronous to clk via the external reset synchronizer. Reset mid-countdown abandons the count.

Test Plan:
- Write EENTRY wvalue 32'h1C00_8FFF, wmask all-ones -> next cycle ex_entry=32'h1C00_8FC0. Read 0x0C returns the same value.
- CRMD PLV=3,IE=1, then wb_ex with ecode 6'h0B, pc 32'h1C00_0100 -> PRMD=32'h7, CRMD[2:0]=0, ERA=32'h1C00_0100, ESTAT[21:16]=6'h0B. Next ertn_flush -> CRMD[2:0]=3'b111.
- wb_ex and csr_we (SAVE0 <- 32'hDEAD) in the same cycle -> SAVE0 unchanged. Masked write with wmask 32'h0000_FFFF over SAVE1=32'h1234_5678, wvalue 32'hAAAA_BBBB -> SAVE1=32'h1234_BBBB.
- TCFG <- 32'h0000_000B (InitVal=2, periodic, en), ECFG.LIE[11]=1, CRMD.IE=1:
  - TVAL reads 8,7,...,0.
  - IS[11] set the cycle after TVAL==0; has_int=1; TVAL reloads 8.
  - TICLR CLR=1 -> IS[11]=0.
- One-shot TCFG 32'h5 -> single expiry, then TVAL stays 0 and IS[11] is not re-set after TICLR. hw_int_in=8'h01 with LIE[2]=1, IE=1 -> has_int=1 two cycles later.
- Assert resetn=0 asynchronously mid-count -> immediately CRMD reads 32'h8, TVAL 0, has_int 0, ex_entry 0.
